bram_copy_engine: RTL and testbench

BRAM_COPY_ENGINE -- requirements
Module: bram_copy_engine

---
 rtl/bram_copy_pkg.sv | 12 +
 rtl/copy_addr_gen.sv | 39 +++
 rtl/bram_copy_engine.sv | 136 +++++++++++++
 tb/tb_bram_copy_engine.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/bram_copy_pkg.sv
// Shared constants for the BRAM copy engine: default widths and FSM state encoding.
package bram_copy_pkg;

    localparam int unsigned DefDataW = 32;
    localparam int unsigned DefAddrW = 9;

    localparam logic [1:0] StIdle   = 2'd0;
    localparam logic [1:0] StStream = 2'd1;
    localparam logic [1:0] StDrain  = 2'd2;
    localparam logic [1:0] StDone   = 2'd3;

endpackage

// File: rtl/copy_addr_gen.sv
// Base-plus-counter address generator with modulo-2^ADDR_W wrap and a terminal-count flag.
module copy_addr_gen #(
    parameter int unsigned ADDR_W = 9
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              load,
    input  logic [ADDR_W-1:0] base,
    input  logic [ADDR_W:0]   count,
    input  logic              step,
    output logic [ADDR_W-1:0] addr,
    output logic              last
);

    localparam logic [ADDR_W:0] CntOne = {{ADDR_W{1'b0}}, 1'b1};

    logic [ADDR_W-1:0] base_q;
    logic [ADDR_W:0]   cnt_q;
    logic [ADDR_W:0]   len_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            base_q <= '0;
            cnt_q  <= '0;
            len_q  <= '0;
        end else if (load) begin
            base_q <= base;
            cnt_q  <= '0;
            len_q  <= count;
        end else if (step) begin
            cnt_q <= cnt_q + CntOne;
        end
    end

    // Truncating the sum gives the wrap for free.
    assign addr = base_q + cnt_q[ADDR_W-1:0];
    assign last = (cnt_q == (len_q - CntOne));

endmodule

// File: rtl/bram_copy_engine.sv
// Streams N words from a source BRAM to a destination BRAM at one word per cycle.
// Optional running checksum of the copied words when COPY_CHECKSUM_EN is defined.
module bram_copy_engine
    import bram_copy_pkg::*;
#(
    parameter int unsigned DATA_W = DefDataW,
    parameter int unsigned ADDR_W = DefAddrW
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    input  logic [ADDR_W:0]       length,
    input  logic [ADDR_W-1:0]     src_base,
    input  logic [ADDR_W-1:0]     dst_base,
    input  logic [DATA_W-1:0]     data_in,
    output logic                  wr_rden,
    output logic [ADDR_W-1:0]     read_address,
    output logic                  rd_wren,
    output logic [DATA_W/8-1:0]   rd_we,
    output logic [ADDR_W-1:0]     write_address,
    output logic [DATA_W-1:0]     data_out,
    output logic                  busy,
`ifdef COPY_CHECKSUM_EN
    output logic                  done,
    output logic [DATA_W-1:0]     checksum
`else
    output logic                  done
`endif
);

    localparam logic [ADDR_W:0] MaxLen = {1'b1, {ADDR_W{1'b0}}};

    logic [1:0]        state_q, state_d;
    logic              accept;
    logic              stream;
    logic              src_last;
    logic              dst_last;
    logic [ADDR_W:0]   len_sat;
    logic              rd_pend_q;
    logic              wr_q;
    logic [DATA_W-1:0] data_q;

    assign accept  = (state_q == StIdle) && start;
    assign stream  = (state_q == StStream);
    assign len_sat = (length > MaxLen) ? MaxLen : length;

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = (len_sat == '0) ? StDone : StStream;
                end
            end
            StStream: begin
                if (src_last) begin
                    state_d = StDrain;
                end
            end
            StDrain: begin
                if (wr_q && dst_last) begin
                    state_d = StDone;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Two-stage pipe: BRAM read latency, then the registered write port.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= StIdle;
            rd_pend_q <= 1'b0;
            wr_q      <= 1'b0;
            data_q    <= '0;
        end else begin
            state_q   <= state_d;
            rd_pend_q <= stream;
            wr_q      <= rd_pend_q;
            if (rd_pend_q) begin
                data_q <= data_in;
            end
        end
    end

    copy_addr_gen #(
        .ADDR_W (ADDR_W)
    ) u_src_gen (
        .clock (clock),
        .reset (reset),
        .load  (accept),
        .base  (src_base),
        .count (len_sat),
        .step  (stream),
        .addr  (read_address),
        .last  (src_last)
    );

    copy_addr_gen #(
        .ADDR_W (ADDR_W)
    ) u_dst_gen (
        .clock (clock),
        .reset (reset),
        .load  (accept),
        .base  (dst_base),
        .count (len_sat),
        .step  (wr_q),
        .addr  (write_address),
        .last  (dst_last)
    );

    assign wr_rden  = stream;
    assign rd_wren  = wr_q;
    assign rd_we    = {(DATA_W/8){wr_q}};
    assign data_out = data_q;
    assign busy     = stream || (state_q == StDrain);
    assign done     = (state_q == StDone);

`ifdef COPY_CHECKSUM_EN
    logic [DATA_W-1:0] sum_q;

    // The last word is written in the cycle before DONE, so the sum is final in DONE.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sum_q <= '0;
        end else if (accept) begin
            sum_q <= '0;
        end else if (wr_q) begin
            sum_q <= sum_q + data_q;
        end
    end

    assign checksum = sum_q;
`endif

endmodule

// File: tb/tb_bram_copy_engine.sv
// Scoreboard bench for bram_copy_engine: randomized copies against a queue-based model.
// Define COPY_CHECKSUM_EN to also check the checksum output.
module tb_bram_copy_engine;

    localparam int DW = 32;
    localparam int AW = 9;
    localparam int DEPTH = 512;

    typedef struct {
        int addr;
        int cyc;
    } rd_t;

    typedef struct {
        int          addr;
        logic [31:0] data;
        int          cyc;
    } wr_t;

    typedef struct {
        int          cyc;
        logic [31:0] sum;
    } done_t;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic [AW:0]   length = '0;
    logic [AW-1:0] src_base = '0;
    logic [AW-1:0] dst_base = '0;
    logic [DW-1:0] data_in = '0;
    logic          wr_rden;
    logic [AW-1:0] read_address;
    logic          rd_wren;
    logic [DW/8-1:0] rd_we;
    logic [AW-1:0] write_address;
    logic [DW-1:0] data_out;
    logic          busy;
    logic          done;
`ifdef COPY_CHECKSUM_EN
    logic [DW-1:0] checksum;
`endif

    bram_copy_engine #(
        .DATA_W (DW),
        .ADDR_W (AW)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .start         (start),
        .length        (length),
        .src_base      (src_base),
        .dst_base      (dst_base),
        .data_in       (data_in),
        .wr_rden       (wr_rden),
        .read_address  (read_address),
        .rd_wren       (rd_wren),
        .rd_we         (rd_we),
        .write_address (write_address),
        .data_out      (data_out),
        .busy          (busy),
`ifdef COPY_CHECKSUM_EN
        .done          (done),
        .checksum      (checksum)
`else
        .done          (done)
`endif
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    // Source BRAM: one-cycle read latency.
    logic [31:0] src_mem [DEPTH];
    always @(posedge clock) begin
        if (wr_rden) data_in <= src_mem[read_address];
    end

    rd_t   exp_rd[$];
    wr_t   exp_wr[$];
    done_t exp_done[$];
    int    busy_lo = 1;
    int    busy_hi = 0;
    int    n_checks = 0;
    int    n_pass = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Model: word i is read at accept+i, written at accept+i+2; done follows the last write,
    // or the accept itself when the copy is empty.
    task automatic issue(input int s, input int d, input int l);
        int          n;
        int          a;
        logic [31:0] sum;
        n = (l > DEPTH) ? DEPTH : l;
        @(negedge clock);
        src_base = AW'(s);
        dst_base = AW'(d);
        length   = (AW+1)'(l);
        start    = 1'b1;
        @(posedge clock);
        #1;
        start = 1'b0;
        a     = cyc;
        sum   = '0;
        for (int i = 0; i < n; i++) begin
            exp_rd.push_back('{addr: (s + i) % DEPTH, cyc: a + i});
            exp_wr.push_back('{addr: (d + i) % DEPTH, data: src_mem[(s + i) % DEPTH],
                               cyc: a + i + 2});
            sum += src_mem[(s + i) % DEPTH];
        end
        exp_done.push_back('{cyc: (n == 0) ? a : a + n + 2, sum: sum});
        busy_lo = a;
        busy_hi = (n == 0) ? a - 1 : a + n + 1;
    endtask

    task automatic flush();
        exp_rd.delete();
        exp_wr.delete();
        exp_done.delete();
        busy_hi = busy_lo - 1;
    endtask

    task automatic wait_done(input int bound);
        for (int t = 0; t < bound && exp_done.size() != 0; t++) @(posedge clock);
        chk("copy_timeout", 64'(exp_done.size() + exp_wr.size() + exp_rd.size()), 0);
        flush();
    endtask

    task automatic copy(input int s, input int d, input int l);
        issue(s, d, l);
        wait_done(((l > DEPTH) ? DEPTH : l) + 12);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_rden"}, wr_rden, 0);
        chk({tag, "_raddr"}, read_address, 0);
        chk({tag, "_wren"}, rd_wren, 0);
        chk({tag, "_we"}, rd_we, 0);
        chk({tag, "_waddr"}, write_address, 0);
        chk({tag, "_dout"}, data_out, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
`ifdef COPY_CHECKSUM_EN
        chk({tag, "_csum"}, checksum, 0);
`endif
    endtask

    // Monitor: pops and compares whenever the DUT presents a read, write or done.
    initial begin
        rd_t   r;
        wr_t   w;
        done_t e;
        forever begin
            @(negedge clock);
            chk("busy", busy, (cyc >= busy_lo) && (cyc <= busy_hi));
            if (wr_rden) begin
                if (exp_rd.size() == 0) chk("rd_unexpected", wr_rden, 0);
                else begin
                    r = exp_rd.pop_front();
                    chk("rd_addr", read_address, r.addr);
                    chk("rd_cycle", cyc, r.cyc);
                end
            end
            if (rd_wren) begin
                if (exp_wr.size() == 0) chk("wr_unexpected", rd_wren, 0);
                else begin
                    w = exp_wr.pop_front();
                    chk("wr_addr", write_address, w.addr);
                    chk("wr_data", data_out, w.data);
                    chk("wr_be", rd_we, 4'hF);
                    chk("wr_cycle", cyc, w.cyc);
                end
            end else begin
                chk("idle_we", rd_we, 0);
            end
            if (done) begin
                if (exp_done.size() == 0) chk("done_unexpected", done, 0);
                else begin
                    e = exp_done.pop_front();
                    chk("done_cycle", cyc, e.cyc);
`ifdef COPY_CHECKSUM_EN
                    chk("checksum", checksum, e.sum);
`endif
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < DEPTH; i++) src_mem[i] = $urandom;
        #3;
        chk_all_zero("reset");
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;

        copy(0, 256, 4);
        copy(7, 40, 0);
        copy(510, 0, 4);

        // Start mid-copy with different arguments must be ignored.
        issue(20, 400, 6);
        repeat (2) @(posedge clock);
        @(negedge clock);
        src_base = 9'd77;
        dst_base = 9'd5;
        length   = 10'd3;
        start    = 1'b1;
        @(negedge clock);
        start = 1'b0;
        wait_done(20);

        // Reset during the third STREAM cycle aborts with no done.
        issue(5, 100, 8);
        repeat (2) @(posedge clock);
        #1;
        chk("pre_reset_stream", wr_rden, 1);
        reset = 1'b1;
        flush();
        #1;
        chk_all_zero("abort");
        repeat (3) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        copy(5, 100, 8);

        src_mem[40] = 32'd1;
        src_mem[41] = 32'd2;
        src_mem[42] = 32'hFFFF_FFFF;
        copy(40, 300, 3);

        // Oversized length saturates to the full memory.
        copy($urandom_range(0, 511), $urandom_range(0, 511), 700);

        for (int k = 0; k < 10; k++) begin
            copy($urandom_range(0, 511), $urandom_range(0, 511), $urandom_range(1, 24));
        end

        repeat (3) @(posedge clock);
        chk("queues_empty", 64'(exp_done.size() + exp_wr.size() + exp_rd.size()), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
